// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package prog_loader_pkg;

    localparam int OPC_W = 4;
    localparam int OPD_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        CSUM,
        DONE,
        ERR
    } state_t;

    function automatic logic is_loading(input state_t s);
        return (s == LEN) || (s == HI) || (s == LO) || (s == CSUM);
    endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// Running XOR of the payload bytes of one load; cleared when a load begins.
module prog_loader_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum ^ data;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream loader: packs {opcode,operand} pairs into program memory and
// releases the VM core on a good checksum. Optional PROG_LOADER_OPCHK_EN
// rejects high-byte values with a nonzero upper nibble.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = 12
) (
    input  logic          eo3,
    input  logic          nF3,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [IW-1:0] mem_wdata,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    // Remaining-word counter must hold both the largest length byte and 2**AW.
    localparam int CW = (AW + 1 > 9) ? AW + 1 : 9;

    state_t          state;
    state_t          next_state;
    logic            take;
    logic            start_load;
    logic            opc_bad;
    logic [CW-1:0]   remaining;
    logic [OPC_W-1:0] opcode;
    logic [7:0]      sum;

    logic            ready_d;
    logic            busy_d;
    logic            cpu_rst_d;
    logic            done_d;
    logic            err_d;

    assign take       = in_valid & in_ready;
    assign start_load = start & ~is_loading(state);

`ifdef PROG_LOADER_OPCHK_EN
    assign opc_bad = |in_data[7:OPC_W];
`else
    assign opc_bad = 1'b0;
`endif

    prog_loader_csum u_csum (
        .clk   (eo3),
        .rst_n (nF3),
        .clr   (start_load),
        .en    (take & ((state == HI) | (state == LO))),
        .data  (in_data),
        .sum   (sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge eo3 or negedge nF3) begin
        if (!nF3) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start) next_state = LEN;
            LEN:             if (take)  next_state = HI;
            HI:              if (take)  next_state = opc_bad ? ERR : LO;
            LO:              if (take)  next_state = (remaining == CW'(1)) ? CSUM : HI;
            CSUM:            if (take)  next_state = (in_data == sum) ? DONE : ERR;
            default:                    next_state = IDLE;
        endcase
    end

    // Status outputs are decoded from next_state and registered, so they
    // change on the same edge as the state itself.
    always_comb begin
        ready_d   = is_loading(next_state);
        busy_d    = is_loading(next_state);
        cpu_rst_d = (next_state != DONE);
        done_d    = (next_state == DONE);
        err_d     = (next_state == ERR);
    end

    always_ff @(posedge eo3 or negedge nF3) begin
        if (!nF3) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= ready_d;
            busy     <= busy_d;
            cpu_rst  <= cpu_rst_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

    // Write pipeline: the word is issued the cycle after its LO byte, and the
    // address advances once that write has been presented.
    always_ff @(posedge eo3 or negedge nF3) begin
        if (!nF3) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            remaining    <= '0;
            opcode       <= '0;
        end else begin
            mem_we <= 1'b0;

            if (start_load) begin
                mem_addr     <= '0;
                words_loaded <= '0;
            end else if (mem_we) begin
                mem_addr     <= mem_addr + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end

            if (take) begin
                case (state)
                    LEN: remaining <= (in_data == 8'h00) ? (CW'(1) << AW) : CW'(in_data);
                    HI:  opcode    <= in_data[OPC_W-1:0];
                    LO: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= IW'({opcode, in_data[OPD_W-1:0]});
                        remaining <= remaining - CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (AW=4): stimulus queues expected writes,
// a negedge monitor pops and compares every mem_we strobe.
module tb_prog_loader;

    localparam int AW = 4;
    localparam int IW = 12;

    logic          eo3 = 1'b0;
    logic          nF3;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    prog_loader #(.AW(AW), .IW(IW)) dut (
        .eo3          (eo3),
        .nF3          (nF3),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 eo3 = ~eo3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    logic prev_we = 1'b0;
    always @(negedge eo3) begin
        wr_t w;
        if (mem_we === 1'b1) begin
            check("we_one_cycle", prev_we, 0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", mem_addr, w.addr);
                check("wr_data", mem_wdata, w.data);
            end
        end
        prev_we = mem_we;
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge eo3); #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
        end
        @(posedge eo3); #1;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge eo3); #1;
        end
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo,
                             input logic [AW-1:0] addr, input bit gap);
        wr_t w;
        w.addr = addr;
        w.data = {hi[3:0], lo};
        exp_q.push_back(w);
        send_byte(hi, gap);
        send_byte(lo, gap);
    endtask

    task automatic pulse_start();
        @(negedge eo3);
        start = 1'b1;
        @(posedge eo3); #1;
        start = 1'b0;
    endtask

    task automatic end_status(input string tag, input logic exp_done, input logic [AW:0] exp_wl);
        check({tag, "_done"},    done, exp_done);
        check({tag, "_err"},     err, !exp_done);
        check({tag, "_cpu_rst"}, cpu_rst, !exp_done);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_ready"},   in_ready, 0);
        check({tag, "_words"},   words_loaded, exp_wl);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        logic [7:0] cs;
        nF3      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check("rst_ready",   in_ready, 0);
        check("rst_we",      mem_we, 0);
        check("rst_addr",    mem_addr, 0);
        check("rst_wdata",   mem_wdata, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_err",     err, 0);
        check("rst_words",   words_loaded, 0);
        @(negedge eo3);
        nF3 = 1'b1;

        // A byte offered while idle must not be consumed.
        in_valid = 1'b1;
        in_data  = 8'h02;
        repeat (3) @(posedge eo3);
        #1;
        check("idle_ready", in_ready, 0);
        check("idle_busy",  busy, 0);

        // Test 1: good load of two words.
        pulse_start();
        check("t1_busy",    busy, 1);
        check("t1_ready",   in_ready, 1);
        check("t1_cpu_rst", cpu_rst, 1);
        send_byte(8'h02, 1'b0);
        send_word(8'h0C, 8'h05, 4'd0, 1'b0);
        send_word(8'h0E, 8'h00, 4'd1, 1'b0);
        send_byte(8'h07, 1'b0);
        in_valid = 1'b0;
        end_status("t1", 1'b1, 5'd2);

        // Test 2: restart from DONE re-asserts cpu_rst; bad checksum.
        pulse_start();
        check("t2_cpu_rst_restart", cpu_rst, 1);
        check("t2_done_cleared",    done, 0);
        check("t2_words_cleared",   words_loaded, 0);
        send_byte(8'h02, 1'b0);
        send_word(8'h0C, 8'h05, 4'd0, 1'b0);
        send_word(8'h0E, 8'h00, 4'd1, 1'b0);
        send_byte(8'h08, 1'b0);
        in_valid = 1'b0;
        end_status("t2", 1'b0, 5'd2);

        // Test 3: length byte 0 loads all 2**AW words.
        pulse_start();
        send_byte(8'h00, 1'b0);
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            send_word(8'(i), 8'(i * 8'h11), 4'(i), 1'b0);
            cs = cs ^ 8'(i) ^ 8'(i * 8'h11);
        end
        send_byte(cs, 1'b0);
        in_valid = 1'b0;
        end_status("t3", 1'b1, 5'd16);
        check("t3_addr_wrap", mem_addr, 0);

        // Test 4: throttled source, one idle cycle after every byte.
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_word(8'h0C, 8'h05, 4'd0, 1'b1);
        send_word(8'h0E, 8'h00, 4'd1, 1'b1);
        send_byte(8'h07, 1'b1);
        end_status("t4", 1'b1, 5'd2);

        // Test 5: reset after the third payload byte, then a fresh load.
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_word(8'h0C, 8'h05, 4'd0, 1'b0);
        send_byte(8'h0E, 1'b0);
        in_valid = 1'b0;
        #2;
        nF3 = 1'b0;
        #1;
        check("t5_rst_busy",    busy, 0);
        check("t5_rst_cpu_rst", cpu_rst, 1);
        check("t5_rst_ready",   in_ready, 0);
        check("t5_rst_words",   words_loaded, 0);
        @(negedge eo3);
        nF3 = 1'b1;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_word(8'h07, 8'hFF, 4'd0, 1'b0);
        send_byte(8'hF8, 1'b0);
        in_valid = 1'b0;
        end_status("t5", 1'b1, 5'd1);

        // Test 6: high byte with a nonzero upper nibble.
        pulse_start();
        send_byte(8'h01, 1'b0);
`ifdef PROG_LOADER_OPCHK_EN
        send_byte(8'h1A, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(posedge eo3);
        #1;
        end_status("t6", 1'b0, 5'd0);
`else
        send_word(8'h1A, 8'h00, 4'd0, 1'b0);
        send_byte(8'h1A, 1'b0);
        in_valid = 1'b0;
        end_status("t6", 1'b1, 5'd1);
`endif

        repeat (4) @(posedge eo3);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
